// File: rtl/uart_tx_word_scheduler_pkg.sv
// Shared definitions for the UART TX word scheduler.
//   - sched_state_t : scheduler FSM state encoding
//   - grant_src_t   : requester identity used by the round-robin arbiter
//   - BYTES_PER_WORD, grant vector bit positions
//   - select_byte() : picks byte idx of a word in MSB- or LSB-first order
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FIFO_LATCH = 3'd1,
        ST_LOAD       = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_GAP        = 3'd4
    } sched_state_t;

    typedef enum logic {
        SRC_FIFO   = 1'b0,
        SRC_STATUS = 1'b1
    } grant_src_t;

    localparam int BYTES_PER_WORD = 4;

    // Bit positions inside the one-hot grant / request vectors.
    localparam int GNT_FIFO_BIT   = 0;
    localparam int GNT_STATUS_BIT = 1;

    // Byte idx of word; idx 0 is the first byte on the wire.
    function automatic logic [7:0] select_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic        msb_first);
        logic [1:0] lane;
        lane = msb_first ? (2'd3 - idx) : idx;
        case (lane)
            2'd0:    select_byte = word[7:0];
            2'd1:    select_byte = word[15:8];
            2'd2:    select_byte = word[23:16];
            2'd3:    select_byte = word[31:24];
            default: select_byte = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_word_scheduler_rr_arbiter.sv
// tx_rr_arbiter: two-way round-robin arbiter between the TX FIFO and the
// status source.
//   clk, rst : clock and asynchronous active-high reset
//   req      : [0] = FIFO request, [1] = status request
//   advance  : the owner is accepting the grant this cycle
//   grant    : one-hot grant, same bit layout as req
// The grant is combinational so the scheduler can act on it in the very
// IDLE cycle it samples the requests; all scheduler outputs stay registered.
module tx_rr_arbiter
    import uart_tx_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    grant_src_t last_grant_r;
    logic [1:0] grant_s;

    // On a tie the source that did not win last time gets the grant.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = (last_grant_r == SRC_FIFO) ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Remember the winner; reset to FIFO so status takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= SRC_FIFO;
        end else if (advance && (grant_s != 2'b00)) begin
            last_grant_r <= grant_s[GNT_STATUS_BIT] ? SRC_STATUS : SRC_FIFO;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/uart_tx_word_scheduler.sv
// uart_tx_word_scheduler: shares a byte-wide UART transmitter between the
// TX data FIFO and a single-word status source, sending each 32-bit word as
// four handshaked bytes with a watchdog on the UART done pulse.
//   i_clock, i_reset        : clock, asynchronous active-high reset
//   i_fifo_empty            : FIFO empty flag
//   o_fifo_rdreq            : one-cycle FIFO read strobe
//   i_fifo_word             : FIFO q, valid the cycle after o_fifo_rdreq
//   i_status_req/_word      : pending status word (held until ack)
//   o_status_ack            : pulse when the status word is latched
//   o_send_next_byte_cmd    : one-cycle UART start strobe
//   o_tx_byte_output        : byte for the UART, held until done
//   i_tx_active, i_tx_done  : UART busy level and completion pulse
//   o_busy                  : scheduler not idle
//   o_timeout               : pulse when a word is aborted by the watchdog
//   o_words_sent            : wrapping count of completed words
module uart_tx_word_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter bit MSB_FIRST    = 1'b1,
    parameter int DONE_TIMEOUT = 8192,
    parameter int TIMEOUT_W    = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rdreq,
    input  logic [31:0] i_fifo_word,
    input  logic        i_status_req,
    input  logic [31:0] i_status_word,
    output logic        o_status_ack,
    output logic        o_send_next_byte_cmd,
    output logic [7:0]  o_tx_byte_output,
    input  logic        i_tx_active,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_timeout,
    output logic [15:0] o_words_sent
);

    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(DONE_TIMEOUT - 1);
    localparam logic [1:0]           LAST_IDX = 2'(BYTES_PER_WORD - 1);

    sched_state_t         state_r;
    logic [1:0]           idx_r;
    logic [TIMEOUT_W-1:0] wd_r;
    logic [31:0]          word_r;
    logic                 latch_wait_r;
    logic [1:0]           req_s;
    logic [1:0]           grant_s;
    logic                 arb_advance_s;

    assign req_s[GNT_FIFO_BIT]   = ~i_fifo_empty;
    assign req_s[GNT_STATUS_BIT] = i_status_req;
    // Requests only matter while idle; mid-word arrivals simply wait.
    assign arb_advance_s         = (state_r == ST_IDLE);

    tx_rr_arbiter u_arb (
        .clk     (i_clock),
        .rst     (i_reset),
        .req     (req_s),
        .advance (arb_advance_s),
        .grant   (grant_s)
    );

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r              <= ST_IDLE;
            idx_r                <= 2'd0;
            wd_r                 <= {TIMEOUT_W{1'b0}};
            word_r               <= 32'd0;
            latch_wait_r         <= 1'b0;
            o_fifo_rdreq         <= 1'b0;
            o_status_ack         <= 1'b0;
            o_send_next_byte_cmd <= 1'b0;
            o_tx_byte_output     <= 8'd0;
            o_busy               <= 1'b0;
            o_timeout            <= 1'b0;
            o_words_sent         <= 16'd0;
        end else begin
            o_fifo_rdreq         <= 1'b0;
            o_status_ack         <= 1'b0;
            o_send_next_byte_cmd <= 1'b0;
            o_timeout            <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s[GNT_STATUS_BIT]) begin
                        word_r       <= i_status_word;
                        o_status_ack <= 1'b1;
                        o_busy       <= 1'b1;
                        state_r      <= ST_LOAD;
                    end else if (grant_s[GNT_FIFO_BIT]) begin
                        o_fifo_rdreq <= 1'b1;
                        latch_wait_r <= 1'b1;
                        o_busy       <= 1'b1;
                        state_r      <= ST_FIFO_LATCH;
                    end else begin
                        o_busy       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_FIFO_LATCH: begin
                    // First cycle here is the rdreq cycle itself; q is only
                    // valid one cycle later.
                    if (latch_wait_r) begin
                        latch_wait_r <= 1'b0;
                    end else begin
                        word_r  <= i_fifo_word;
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!i_tx_active) begin
                        o_tx_byte_output     <= select_byte(word_r, idx_r, MSB_FIRST);
                        o_send_next_byte_cmd <= 1'b1;
                        wd_r                 <= {TIMEOUT_W{1'b0}};
                        state_r              <= ST_WAIT_DONE;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_WAIT_DONE: begin
                    // Done is checked first so it wins over a same-cycle expiry.
                    if (i_tx_done) begin
                        if (idx_r == LAST_IDX) begin
                            o_words_sent <= o_words_sent + 16'd1;
                            idx_r        <= 2'd0;
                            o_busy       <= 1'b0;
                            state_r      <= ST_IDLE;
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            state_r <= ST_GAP;
                        end
                    end else if (wd_r == WD_LIMIT) begin
                        o_timeout <= 1'b1;
                        idx_r     <= 2'd0;
                        o_busy    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        wd_r <= wd_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_GAP: begin
                    // Lets the UART finish its post-done cleanup cycle.
                    state_r <= ST_LOAD;
                end
                default: begin
                    idx_r   <= 2'd0;
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word_scheduler.sv
// Self-checking bench for uart_tx_word_scheduler. dut_a is MSB-first with a
// short watchdog; dut_b is LSB-first. Byte scoreboards: expected bytes are
// queued when words are offered, strobed bytes are captured by monitors.
module tb_uart_tx_word_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- DUT A (MSB first, DONE_TIMEOUT = 64) ----------------
    logic        a_empty, a_rdreq, a_stat_req, a_ack, a_cmd;
    logic        a_active, a_done, a_busy, a_to;
    logic [31:0] a_word, a_stat_word;
    logic [7:0]  a_byte;
    logic [15:0] a_ws;

    uart_tx_word_scheduler #(.MSB_FIRST(1'b1), .DONE_TIMEOUT(64), .TIMEOUT_W(16)) dut_a (
        .i_clock(clk), .i_reset(rst),
        .i_fifo_empty(a_empty), .o_fifo_rdreq(a_rdreq), .i_fifo_word(a_word),
        .i_status_req(a_stat_req), .i_status_word(a_stat_word), .o_status_ack(a_ack),
        .o_send_next_byte_cmd(a_cmd), .o_tx_byte_output(a_byte),
        .i_tx_active(a_active), .i_tx_done(a_done),
        .o_busy(a_busy), .o_timeout(a_to), .o_words_sent(a_ws)
    );

    // FIFO A: normal (non-show-ahead) FIFO
    logic [31:0] a_mem [0:15];
    int a_wr = 0;
    int a_rd = 0;
    assign a_empty = (a_wr == a_rd);
    initial a_word = 32'd0;
    always @(posedge clk) begin
        if (a_rdreq && (a_wr != a_rd)) begin
            a_word <= a_mem[a_rd % 16];
            a_rd   <= a_rd + 1;
        end
    end

    // UART A: done 40 clocks after strobe; optional hang / extended active
    bit a_hang  = 1'b0;
    int a_extra = 0;
    int a_ucnt  = 0;
    int a_post  = 0;
    initial begin a_active = 1'b0; a_done = 1'b0; end
    always @(posedge clk) begin
        a_done <= 1'b0;
        if (rst) begin
            a_active <= 1'b0; a_ucnt <= 0; a_post <= 0;
        end else if (a_cmd) begin
            a_active <= 1'b1; a_ucnt <= 40;
        end else if (a_ucnt > 0) begin
            a_ucnt <= a_ucnt - 1;
            if (a_ucnt == 1) begin
                if (a_hang) begin
                    a_active <= 1'b0;
                end else begin
                    a_done <= 1'b1;
                    a_post <= a_extra;
                    if (a_extra == 0) a_active <= 1'b0;
                end
            end
        end else if (a_post > 0) begin
            a_post <= a_post - 1;
            if (a_post == 1) a_active <= 1'b0;
        end
    end

    // Monitor A
    logic [7:0] a_got [0:127];
    int a_gw = 0, a_gr = 0;
    int a_done_cnt = 0, a_rd_cnt = 0, a_ack_cnt = 0, a_to_cnt = 0;
    int a_last_done = 0, a_last_cmd = 0, a_to_cyc = 0, a_gap = 0, a_overlap = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (a_cmd) begin
            a_got[a_gw % 128] <= a_byte;
            a_gw       <= a_gw + 1;
            a_last_cmd <= cyc;
            a_gap      <= cyc - a_last_done;
            if (a_active) a_overlap <= a_overlap + 1;
        end
        if (a_done) begin a_last_done <= cyc; a_done_cnt <= a_done_cnt + 1; end
        if (a_rdreq) a_rd_cnt <= a_rd_cnt + 1;
        if (a_ack) a_ack_cnt <= a_ack_cnt + 1;
        if (a_to) begin a_to_cnt <= a_to_cnt + 1; a_to_cyc <= cyc; end
    end

    // ---------------- DUT B (LSB first) ----------------
    logic        b_empty, b_rdreq, b_ack, b_cmd, b_active, b_done, b_busy, b_to;
    logic        b_stat_req;
    logic [31:0] b_word, b_stat_word, b_src;
    logic [7:0]  b_byte;
    logic [15:0] b_ws;
    logic [39:0] b_sh;

    uart_tx_word_scheduler #(.MSB_FIRST(1'b0)) dut_b (
        .i_clock(clk), .i_reset(rst),
        .i_fifo_empty(b_empty), .o_fifo_rdreq(b_rdreq), .i_fifo_word(b_word),
        .i_status_req(b_stat_req), .i_status_word(b_stat_word), .o_status_ack(b_ack),
        .o_send_next_byte_cmd(b_cmd), .o_tx_byte_output(b_byte),
        .i_tx_active(b_active), .i_tx_done(b_done),
        .o_busy(b_busy), .o_timeout(b_to), .o_words_sent(b_ws)
    );

    int b_wcnt = 0, b_rcnt = 0;
    assign b_empty  = (b_wcnt == b_rcnt);
    assign b_done   = b_sh[39];
    assign b_active = |b_sh;
    initial begin b_word = 32'd0; b_sh = 40'd0; b_src = 32'd0; end
    always @(posedge clk) begin
        if (b_rdreq && (b_wcnt != b_rcnt)) begin
            b_word <= b_src;
            b_rcnt <= b_rcnt + 1;
        end
        if (rst) b_sh <= 40'd0;
        else     b_sh <= {b_sh[38:0], b_cmd};
    end

    logic [7:0] b_got [0:15];
    int b_gw = 0, b_gr = 0;
    always @(negedge clk) begin
        if (b_cmd) begin
            b_got[b_gw % 16] <= b_byte;
            b_gw <= b_gw + 1;
        end
    end

    // ---------------- Scoreboard helpers ----------------
    logic [7:0] a_exp [$];
    logic [7:0] b_exp [$];

    task automatic push_a_word(input logic [31:0] w, input int nbytes);
        a_mem[a_wr % 16] = w;
        a_wr = a_wr + 1;
        for (int i = 0; i < nbytes; i++) a_exp.push_back(8'((w >> (8 * (3 - i))) & 32'hFF));
    endtask

    task automatic wait_a_bytes(input string name);
        int n;
        n = 0;
        while ((a_gw - a_gr) < a_exp.size() && n < 3000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        if ((a_gw - a_gr) < a_exp.size()) begin
            checks++; errors++;
            $display("FAIL %s_wait: got %0d bytes, required %0d", name, a_gw - a_gr, a_exp.size());
        end
    endtask

    task automatic wait_a_ws(input logic [15:0] target);
        for (int n = 0; n < 300 && a_ws !== target; n++) @(negedge clk);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_stat_req = 1'b0; a_stat_word = 32'd0;
        b_stat_req = 1'b0; b_stat_word = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_rdreq, a_ack, a_cmd, a_byte, a_busy, a_to, a_ws} !== 29'd0) begin
            errors++;
            $display("FAIL reset_a: outputs %h, required 0", {a_rdreq, a_ack, a_cmd, a_byte, a_busy, a_to, a_ws});
        end
        checks++;
        if ({b_rdreq, b_ack, b_cmd, b_byte, b_busy, b_to, b_ws} !== 29'd0) begin
            errors++;
            $display("FAIL reset_b: outputs %h, required 0", {b_rdreq, b_ack, b_cmd, b_byte, b_busy, b_to, b_ws});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        logic [31:0] w;
        logic [7:0]  e, g;
        w = 32'hA1B2C3D4;
        b_src = w;
        for (int i = 0; i < 4; i++) b_exp.push_back(8'((w >> (8 * i)) & 32'hFF));
        b_wcnt = b_wcnt + 1;
        for (int n = 0; n < 3000 && (b_gw - b_gr) < 4; n++) @(negedge clk);
        @(negedge clk);
        if ((b_gw - b_gr) < 4) begin
            checks++; errors++;
            $display("FAIL lsb_wait: got %0d bytes, required 4", b_gw - b_gr);
        end
        while (b_exp.size() > 0 && b_gr < b_gw) begin
            e = b_exp.pop_front(); g = b_got[b_gr % 16]; b_gr++;
            checks++;
            if (g !== e) begin errors++; $display("FAIL lsb_byte: got %h, required %h", g, e); end
        end
        b_exp.delete();
        for (int n = 0; n < 300 && b_ws !== 16'd1; n++) @(negedge clk);
        checks++;
        if (b_ws !== 16'd1) begin errors++; $display("FAIL lsb_words_sent: got %0d, required 1", b_ws); end
    endtask

    task automatic test_msb_first();
        logic [7:0] e, g;
        int rd0;
        rd0 = a_rd_cnt;
        push_a_word(32'hA1B2C3D4, 4);
        wait_a_bytes("msb");
        while (a_exp.size() > 0 && a_gr < a_gw) begin
            e = a_exp.pop_front(); g = a_got[a_gr % 128]; a_gr++;
            checks++;
            if (g !== e) begin errors++; $display("FAIL msb_byte: got %h, required %h", g, e); end
        end
        a_exp.delete();
        wait_a_ws(16'd1);
        checks++;
        if (a_ws !== 16'd1) begin errors++; $display("FAIL msb_words_sent: got %0d, required 1", a_ws); end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL msb_busy_fall: got %b, required 0", a_busy); end
        checks++;
        if (a_rd_cnt - rd0 != 1) begin errors++; $display("FAIL msb_rdreq_count: got %0d, required 1", a_rd_cnt - rd0); end
        checks++;
        if (a_gap != 3) begin errors++; $display("FAIL msb_done_to_strobe: got %0d, required 3", a_gap); end
        checks++;
        if (a_overlap != 0) begin errors++; $display("FAIL msb_overlap: got %0d, required 0", a_overlap); end
    endtask

    task automatic test_arbitration();
        logic [7:0] e, g;
        int ack0;
        rst = 1'b1;
        @(negedge clk);
        ack0 = a_ack_cnt;
        a_stat_word = 32'hDEADBEEF;
        a_stat_req  = 1'b1;
        for (int i = 0; i < 4; i++) a_exp.push_back(8'((a_stat_word >> (8 * (3 - i))) & 32'hFF));
        push_a_word(32'h01020304, 4);
        push_a_word(32'h05060708, 4);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_ack !== 1'b1 || a_rdreq !== 1'b0) begin
            errors++;
            $display("FAIL arb_first_grant: ack=%b rdreq=%b, required ack=1 rdreq=0", a_ack, a_rdreq);
        end
        a_stat_req = 1'b0;
        wait_a_bytes("arb");
        while (a_exp.size() > 0 && a_gr < a_gw) begin
            e = a_exp.pop_front(); g = a_got[a_gr % 128]; a_gr++;
            checks++;
            if (g !== e) begin errors++; $display("FAIL arb_byte: got %h, required %h", g, e); end
        end
        a_exp.delete();
        wait_a_ws(16'd3);
        checks++;
        if (a_ack_cnt - ack0 != 1) begin errors++; $display("FAIL arb_ack_count: got %0d, required 1", a_ack_cnt - ack0); end
        checks++;
        if (a_ws !== 16'd3) begin errors++; $display("FAIL arb_words_sent: got %0d, required 3", a_ws); end
    endtask

    task automatic test_timeout();
        logic [7:0]  e, g;
        logic [15:0] ws0;
        int to0;
        ws0 = a_ws;
        to0 = a_to_cnt;
        a_hang = 1'b1;
        push_a_word(32'hCAFEF00D, 1);
        for (int n = 0; n < 600 && a_to_cnt == to0; n++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_to_cnt - to0 != 1) begin
            errors++; $display("FAIL timeout_pulse: got %0d pulses, required 1", a_to_cnt - to0);
        end else begin
            checks++;
            if (a_to_cyc - a_last_cmd != 64) begin
                errors++; $display("FAIL timeout_latency: got %0d clocks, required 64", a_to_cyc - a_last_cmd);
            end
        end
        checks++;
        if (a_ws !== ws0) begin errors++; $display("FAIL timeout_words_sent: got %0d, required %0d", a_ws, ws0); end
        a_hang = 1'b0;
        push_a_word(32'h0BADC0DE, 4);
        wait_a_bytes("timeout");
        while (a_exp.size() > 0 && a_gr < a_gw) begin
            e = a_exp.pop_front(); g = a_got[a_gr % 128]; a_gr++;
            checks++;
            if (g !== e) begin errors++; $display("FAIL timeout_byte: got %h, required %h", g, e); end
        end
        a_exp.delete();
        wait_a_ws(ws0 + 16'd1);
        checks++;
        if (a_ws !== ws0 + 16'd1) begin errors++; $display("FAIL timeout_next_word: got %0d, required %0d", a_ws, ws0 + 16'd1); end
    endtask

    task automatic test_reset_midword();
        logic [7:0] e, g;
        int d0;
        d0 = a_done_cnt;
        push_a_word(32'h11223344, 2);
        for (int n = 0; n < 3000 && a_done_cnt < d0 + 2; n++) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({a_rdreq, a_ack, a_cmd, a_byte, a_busy, a_to, a_ws} !== 29'd0) begin
            errors++;
            $display("FAIL midword_reset_outputs: got %h, required 0", {a_rdreq, a_ack, a_cmd, a_byte, a_busy, a_to, a_ws});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        while (a_exp.size() > 0 && a_gr < a_gw) begin
            e = a_exp.pop_front(); g = a_got[a_gr % 128]; a_gr++;
            checks++;
            if (g !== e) begin errors++; $display("FAIL midword_byte: got %h, required %h", g, e); end
        end
        checks++;
        if (a_exp.size() != 0) begin errors++; $display("FAIL midword_bytes_before_reset: missing %0d, required 0", a_exp.size()); end
        a_exp.delete();
        push_a_word(32'h55667788, 4);
        wait_a_bytes("after_reset");
        while (a_exp.size() > 0 && a_gr < a_gw) begin
            e = a_exp.pop_front(); g = a_got[a_gr % 128]; a_gr++;
            checks++;
            if (g !== e) begin errors++; $display("FAIL after_reset_byte: got %h, required %h", g, e); end
        end
        a_exp.delete();
        wait_a_ws(16'd1);
        checks++;
        if (a_ws !== 16'd1) begin errors++; $display("FAIL after_reset_words_sent: got %0d, required 1", a_ws); end
    endtask

    task automatic test_tx_active_hold();
        logic [7:0] e, g;
        int ov0;
        ov0 = a_overlap;
        a_extra = 10;
        push_a_word(32'h99AABBCC, 4);
        wait_a_bytes("active_hold");
        while (a_exp.size() > 0 && a_gr < a_gw) begin
            e = a_exp.pop_front(); g = a_got[a_gr % 128]; a_gr++;
            checks++;
            if (g !== e) begin errors++; $display("FAIL active_hold_byte: got %h, required %h", g, e); end
        end
        a_exp.delete();
        checks++;
        if (a_gap != 11) begin errors++; $display("FAIL active_hold_done_to_strobe: got %0d, required 11", a_gap); end
        checks++;
        if (a_overlap != ov0) begin errors++; $display("FAIL active_hold_overlap: got %0d, required 0", a_overlap - ov0); end
        wait_a_ws(16'd2);
        checks++;
        if (a_ws !== 16'd2) begin errors++; $display("FAIL active_hold_words_sent: got %0d, required 2", a_ws); end
        a_extra = 0;
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_arbitration();
        test_timeout();
        test_reset_midword();
        test_tx_active_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
